// File: rtl/jtag_tap.sv
// JTAG TAP controller running entirely on clk; TCK/TMS/TDI/TRSTn are oversampled pins.
// Optional user debug DR (DBG instruction) enabled by defining JTAG_TAP_USER_DR_EN.
`timescale 1ns/1ps
module jtag_tap #(
   parameter int unsigned IR_WIDTH = 5,
   parameter int unsigned DR_WIDTH = 32,
   parameter logic [31:0] IDCODE   = 32'h1DC0_0001
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                tck,
   input  logic                tms,
   input  logic                tdi,
   input  logic                trstn,
   output logic                tdo,
   output logic                tdo_en,
   output logic [3:0]          tap_state,
   output logic [IR_WIDTH-1:0] ir,
   input  logic [DR_WIDTH-1:0] dbg_capture_data,
   output logic [DR_WIDTH-1:0] dbg_update_data,
   output logic                dbg_update_valid
);

   typedef enum logic [3:0] {
      TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
      SH_DR  = 4'h2, EX1_DR = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0,
      UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
      EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
   } state_t;

   localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);

   state_t              state, next_state;
   logic [2:0]          tck_s;
   logic [1:0]          tms_s, tdi_s, trstn_s;
   logic                tck_rise, tck_fall, tms_sync, tdi_sync, tap_rst;
   logic                capture_ir, shift_ir, update_ir;
   logic                capture_dr, shift_dr, update_dr;
   logic [IR_WIDTH-1:0] ir_shift;
   logic [31:0]         idcode_sr;
   logic                bypass_reg, dr_lsb;

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         tck_s   <= 3'b000;
         tms_s   <= 2'b11;
         tdi_s   <= 2'b00;
         trstn_s <= 2'b11;
      end else begin
         tck_s   <= {tck_s[1:0], tck};
         tms_s   <= {tms_s[0], tms};
         tdi_s   <= {tdi_s[0], tdi};
         trstn_s <= {trstn_s[0], trstn};
      end
   end

   assign tck_rise  = tck_s[1] & ~tck_s[2];
   assign tck_fall  = ~tck_s[1] & tck_s[2];
   assign tms_sync  = tms_s[1];
   assign tdi_sync  = tdi_s[1];
   assign tap_rst   = ~trstn_s[1];
   assign tap_state = state;

   always_ff @(posedge clk) begin
      if (!rstn || tap_rst) state <= TLR;
      else if (tck_rise)    state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         TLR:     next_state = tms_sync ? TLR    : RTI;
         RTI:     next_state = tms_sync ? SEL_DR : RTI;
         SEL_DR:  next_state = tms_sync ? SEL_IR : CAP_DR;
         CAP_DR:  next_state = tms_sync ? EX1_DR : SH_DR;
         SH_DR:   next_state = tms_sync ? EX1_DR : SH_DR;
         EX1_DR:  next_state = tms_sync ? UPD_DR : PAU_DR;
         PAU_DR:  next_state = tms_sync ? EX2_DR : PAU_DR;
         EX2_DR:  next_state = tms_sync ? UPD_DR : SH_DR;
         UPD_DR:  next_state = tms_sync ? SEL_DR : RTI;
         SEL_IR:  next_state = tms_sync ? TLR    : CAP_IR;
         CAP_IR:  next_state = tms_sync ? EX1_IR : SH_IR;
         SH_IR:   next_state = tms_sync ? EX1_IR : SH_IR;
         EX1_IR:  next_state = tms_sync ? UPD_IR : PAU_IR;
         PAU_IR:  next_state = tms_sync ? EX2_IR : PAU_IR;
         EX2_IR:  next_state = tms_sync ? UPD_IR : SH_IR;
         UPD_IR:  next_state = tms_sync ? SEL_DR : RTI;
         default: next_state = TLR;
      endcase
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      capture_ir = 1'b0;
      shift_ir   = 1'b0;
      update_ir  = 1'b0;
      capture_dr = 1'b0;
      shift_dr   = 1'b0;
      update_dr  = 1'b0;
      case (state)
         CAP_IR:  capture_ir = 1'b1;
         SH_IR:   shift_ir   = 1'b1;
         UPD_IR:  update_ir  = 1'b1;
         CAP_DR:  capture_dr = 1'b1;
         SH_DR:   shift_dr   = 1'b1;
         UPD_DR:  update_dr  = 1'b1;
         default: ;
      endcase
      tdo_en = shift_ir | shift_dr;
   end

   // NOTE: shift registers carry no reset; capture always reloads them before they are observed.
   always_ff @(posedge clk) begin
      if (tck_rise) begin
         if (capture_ir)    ir_shift <= IR_WIDTH'(1);
         else if (shift_ir) ir_shift <= {tdi_sync, ir_shift[IR_WIDTH-1:1]};
         if (capture_dr) begin
            bypass_reg <= 1'b0;
            idcode_sr  <= IDCODE;
         end else if (shift_dr) begin
            bypass_reg <= tdi_sync;
            idcode_sr  <= {tdi_sync, idcode_sr[31:1]};
         end
      end
   end

   // tdo and the instruction only change on TCK falls, as the probe expects.
   always_ff @(posedge clk) begin
      if (!rstn || tap_rst) begin
         ir  <= IR_IDCODE;
         tdo <= 1'b0;
      end else begin
         if (state == TLR) ir <= IR_IDCODE;
         if (tck_fall) begin
            tdo <= shift_ir ? ir_shift[0] : (shift_dr ? dr_lsb : 1'b0);
            if (update_ir) ir <= ir_shift;
         end
      end
   end

`ifdef JTAG_TAP_USER_DR_EN
   localparam logic [IR_WIDTH-1:0] IR_DBG = IR_WIDTH'(5'h10);
   logic [DR_WIDTH-1:0] user_sr;

   assign dr_lsb = (ir == IR_IDCODE) ? idcode_sr[0] :
                   (ir == IR_DBG)    ? user_sr[0]   : bypass_reg;

   always_ff @(posedge clk) begin
      if (tck_rise) begin
         if (capture_dr)    user_sr <= dbg_capture_data;
         else if (shift_dr) user_sr <= {tdi_sync, user_sr[DR_WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn || tap_rst) begin
         dbg_update_data  <= '0;
         dbg_update_valid <= 1'b0;
      end else begin
         dbg_update_valid <= 1'b0;
         if (tck_fall && update_dr && ir == IR_DBG) begin
            dbg_update_data  <= user_sr;
            dbg_update_valid <= 1'b1;
         end
      end
   end
`else
   logic unused_dbg;

   assign dr_lsb           = (ir == IR_IDCODE) ? idcode_sr[0] : bypass_reg;
   assign dbg_update_data  = '0;
   assign dbg_update_valid = 1'b0;
   assign unused_dbg       = ^{dbg_capture_data, update_dr};
`endif

endmodule
